// File: rtl/display_pkg.sv
// Shared types and elaboration helpers for the binary-coded-modulation panel driver.
package display_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        LATCH,
        BLANK,
        SHOW,
        FLIP
    } state_t;

    // Smallest width that can index `value` distinct items.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/display_bcm_timer.sv
// Down-counter for one SHOW interval: total duration plus the leading oe-on stretch.
module display_bcm_timer #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [width-1:0] duration,
    input  logic [width-1:0] on_length,
    output logic             done,
    output logic             oe_active
);

    logic [width-1:0] remaining;
    logic [width-1:0] on_left;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
            on_left   <= '0;
            oe_active <= 1'b0;
        end else if (load) begin
            remaining <= duration;
            on_left   <= on_length;
            oe_active <= (on_length != '0);
        end else if (remaining != '0) begin
            remaining <= remaining - width'(1);
            on_left   <= (on_left != '0) ? on_left - width'(1) : '0;
            oe_active <= (on_left > width'(1));
        end else begin
            oe_active <= 1'b0;
        end
    end

    // High during the final SHOW cycle.
    assign done = (remaining == width'(1));

endmodule

// File: rtl/display_driver_bcm.sv
// Row-scanned LED panel driver: shifts each bitplane, latches it, then shows it for a
// binary-weighted time with a global brightness duty on oe.
module display_driver_bcm
    import display_pkg::*;
#(
    parameter int rows     = 16,
    parameter int columns  = 64,
    parameter int bitdepth = 8,
    parameter int unit     = 8,
    parameter int blank    = 2
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             enable,
    input  logic [7:0]                                       brightness,
    output logic [clog2(rows)-1:0]                           row,
    output logic [clog2(columns)-1:0]                        column,
    output logic [((bitdepth > 1) ? clog2(bitdepth) : 1)-1:0] bitplane,
    output logic                                             oe,
    output logic                                             lat,
    output logic                                             oclk,
    output logic                                             safe_flip
);

    localparam int ROW_W   = clog2(rows);
    localparam int COL_W   = clog2(columns);
    localparam int PLANE_W = (bitdepth > 1) ? clog2(bitdepth) : 1;
    localparam int TIME_W  = clog2(unit * (1 << (bitdepth - 1)) + 1);
    localparam int PROD_W  = TIME_W + 9;
    localparam int BLANK_W = (blank > 0) ? clog2(blank + 1) : 1;

    state_t             state, state_n;
    logic [ROW_W-1:0]   row_n;
    logic [COL_W-1:0]   column_n;
    logic [PLANE_W-1:0] bitplane_n;
    logic               phase, phase_n;
    logic [BLANK_W-1:0] blank_cnt, blank_n;
    logic               lat_n, oclk_n, flip_n;
    logic               timer_load, timer_done;
    logic [TIME_W-1:0]  show_duration, on_length;
    logic [PROD_W-1:0]  duty_product;

    // Plane weight and duty come from the plane about to be shown; brightness is
    // captured by the timer only on its load cycle.
    assign show_duration = TIME_W'(unit) << bitplane;
    assign duty_product  = PROD_W'(show_duration) * PROD_W'({1'b0, brightness} + 9'd1);
    assign on_length     = TIME_W'(duty_product >> 8);

    // NOTE: every signal gets a default first so no latch is inferred.
    always_comb begin
        state_n    = state;
        row_n      = row;
        column_n   = column;
        bitplane_n = bitplane;
        phase_n    = phase;
        blank_n    = blank_cnt;
        lat_n      = 1'b0;
        oclk_n     = 1'b0;
        flip_n     = 1'b0;
        timer_load = 1'b0;
        case (state)
            IDLE: begin
                row_n      = '0;
                column_n   = '0;
                bitplane_n = '0;
                phase_n    = 1'b0;
                if (enable) begin
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (!phase) begin
                    phase_n = 1'b1;
                    oclk_n  = 1'b1;
                end else begin
                    phase_n = 1'b0;
                    if (column == COL_W'(columns - 1)) begin
                        state_n  = LATCH;
                        column_n = '0;
                        lat_n    = 1'b1;
                    end else begin
                        column_n = column + COL_W'(1);
                    end
                end
            end
            LATCH: begin
                if (blank == 0) begin
                    state_n    = SHOW;
                    timer_load = 1'b1;
                end else begin
                    state_n = BLANK;
                    blank_n = BLANK_W'(blank - 1);
                end
            end
            BLANK: begin
                if (blank_cnt == '0) begin
                    state_n    = SHOW;
                    timer_load = 1'b1;
                end else begin
                    blank_n = blank_cnt - BLANK_W'(1);
                end
            end
            SHOW: begin
                if (timer_done) begin
                    phase_n  = 1'b0;
                    column_n = '0;
                    if (bitplane != PLANE_W'(bitdepth - 1)) begin
                        state_n    = SHIFT;
                        bitplane_n = bitplane + PLANE_W'(1);
                    end else if (row != ROW_W'(rows - 1)) begin
                        state_n    = SHIFT;
                        bitplane_n = '0;
                        row_n      = row + ROW_W'(1);
                    end else begin
                        state_n = FLIP;
                        flip_n  = 1'b1;
                    end
                end
            end
            FLIP: begin
                row_n      = '0;
                bitplane_n = '0;
                column_n   = '0;
                phase_n    = 1'b0;
                state_n    = enable ? SHIFT : IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row       <= '0;
            column    <= '0;
            bitplane  <= '0;
            phase     <= 1'b0;
            blank_cnt <= '0;
            lat       <= 1'b0;
            oclk      <= 1'b0;
            safe_flip <= 1'b0;
        end else begin
            state     <= state_n;
            row       <= row_n;
            column    <= column_n;
            bitplane  <= bitplane_n;
            phase     <= phase_n;
            blank_cnt <= blank_n;
            lat       <= lat_n;
            oclk      <= oclk_n;
            safe_flip <= flip_n;
        end
    end

    // The timer's oe_active flop drives the panel enable directly.
    display_bcm_timer #(
        .width(TIME_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .duration (show_duration),
        .on_length(on_length),
        .done     (timer_done),
        .oe_active(oe)
    );

endmodule

// File: tb/tb_display_driver_bcm.sv
// Scoreboard bench: each scenario pushes the expected per-cycle output trace, a negedge
// monitor pops and compares it and also checks the oe/lat/oclk exclusivity invariants.
module tb_display_driver_bcm;

    localparam int ROWS    = 2;
    localparam int COLS    = 4;
    localparam int BD      = 2;
    localparam int UNIT    = 4;
    localparam int BLANK   = 2;
    localparam int ROW_W   = $clog2(ROWS);
    localparam int COL_W   = $clog2(COLS);
    localparam int PL_W    = (BD > 1) ? $clog2(BD) : 1;
    localparam int FRAME   = ROWS * (BD * (2 * COLS + 1 + BLANK) + UNIT * ((1 << BD) - 1)) + 1;

    typedef struct {
        logic             oe;
        logic             lat;
        logic             oclk;
        logic             flip;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic [PL_W-1:0]  plane;
        bit               col_care;
        bit               rp_care;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [7:0]       brightness;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] column;
    logic [PL_W-1:0]  bitplane;
    logic             oe, lat, oclk, safe_flip;

    exp_t exp_q[$];
    exp_t frame_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc = 0;
    int   n_oclk_rise, n_lat, n_oe, n_flip, last_flip_cyc, flip_gap;
    bit   inv_on = 1'b0;

    display_driver_bcm #(
        .rows(ROWS), .columns(COLS), .bitdepth(BD), .unit(UNIT), .blank(BLANK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .brightness(brightness),
        .row       (row),
        .column    (column),
        .bitplane  (bitplane),
        .oe        (oe),
        .lat       (lat),
        .oclk      (oclk),
        .safe_flip (safe_flip)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic e_oe, input logic e_lat, input logic e_oclk,
                                input logic e_flip, input int r, input int c, input int p,
                                input bit cc, input bit rc);
        exp_t e;
        e.oe = e_oe; e.lat = e_lat; e.oclk = e_oclk; e.flip = e_flip;
        e.row = ROW_W'(r); e.col = COL_W'(c); e.plane = PL_W'(p);
        e.col_care = cc; e.rp_care = rc;
        return e;
    endfunction

    // Expected trace of one frame; br_first applies to the first SHOW only.
    task automatic build_frame(input int br_first, input int br_rest);
        int dur, on_len, br;
        bit first;
        frame_q.delete();
        first = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            for (int p = 0; p < BD; p++) begin
                for (int c = 0; c < COLS; c++) begin
                    frame_q.push_back(mk(0, 0, 0, 0, r, c, p, 1, 1));
                    frame_q.push_back(mk(0, 0, 1, 0, r, c, p, 1, 1));
                end
                frame_q.push_back(mk(0, 1, 0, 0, r, 0, p, 0, 1));
                for (int k = 0; k < BLANK; k++) frame_q.push_back(mk(0, 0, 0, 0, r, 0, p, 0, 1));
                br = first ? br_first : br_rest;
                first = 1'b0;
                dur = UNIT * (2 ** p);
                on_len = (dur * (br + 1)) / 256;
                for (int k = 0; k < dur; k++) frame_q.push_back(mk(k < on_len, 0, 0, 0, r, 0, p, 0, 1));
            end
        end
        frame_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1));
    endtask

    task automatic push_frame(input int count);
        for (int i = 0; i < count && i < frame_q.size(); i++) exp_q.push_back(frame_q[i]);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        n_oclk_rise = 0; n_lat = 0; n_oe = 0; n_flip = 0; last_flip_cyc = -1; flip_gap = -1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic monitor();
        exp_t e;
        logic prev_oe = 1'b0, prev_oclk = 1'b0;
        logic [ROW_W-1:0] prev_row = '0;
        logic [PL_W-1:0]  prev_plane = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (oe !== e.oe || lat !== e.lat || oclk !== e.oclk || safe_flip !== e.flip
                    || (e.rp_care && (row !== e.row || bitplane !== e.plane))
                    || (e.col_care && column !== e.col)) begin
                    n_fail++;
                    $display("FAIL trace cycle %0d: got oe=%b lat=%b oclk=%b flip=%b row=%0d col=%0d plane=%0d, required oe=%b lat=%b oclk=%b flip=%b row=%0d col=%0d plane=%0d",
                             cyc, oe, lat, oclk, safe_flip, row, column, bitplane,
                             e.oe, e.lat, e.oclk, e.flip, e.row, e.col, e.plane);
                end
            end
            if (inv_on) begin
                n_checks++;
                if (int'(oe === 1'b1) + int'(lat === 1'b1) + int'(oclk === 1'b1) > 1) begin
                    n_fail++;
                    $display("FAIL exclusive cycle %0d: got oe=%b lat=%b oclk=%b, required at most one high",
                             cyc, oe, lat, oclk);
                end
                if (oe === 1'b1 && prev_oe === 1'b1) begin
                    n_checks++;
                    if (row !== prev_row || bitplane !== prev_plane) begin
                        n_fail++;
                        $display("FAIL stable_under_oe cycle %0d: got row=%0d plane=%0d, required row=%0d plane=%0d",
                                 cyc, row, bitplane, prev_row, prev_plane);
                    end
                end
                if (oclk === 1'b1 && prev_oclk !== 1'b1) n_oclk_rise++;
                if (lat === 1'b1) n_lat++;
                if (oe === 1'b1) n_oe++;
                if (safe_flip === 1'b1) begin
                    n_flip++;
                    if (last_flip_cyc >= 0) flip_gap = cyc - last_flip_cyc;
                    last_flip_cyc = cyc;
                end
            end
            prev_oe = oe; prev_oclk = oclk; prev_row = row; prev_plane = bitplane;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; brightness = 8'd255;
        step(3);
        rst = 1'b0;
        n_checks += 7;
        if (oe !== 1'b0)        begin n_fail++; $display("FAIL reset_oe: got %b, required 0", oe); end
        if (lat !== 1'b0)       begin n_fail++; $display("FAIL reset_lat: got %b, required 0", lat); end
        if (oclk !== 1'b0)      begin n_fail++; $display("FAIL reset_oclk: got %b, required 0", oclk); end
        if (safe_flip !== 1'b0) begin n_fail++; $display("FAIL reset_flip: got %b, required 0", safe_flip); end
        if (row !== '0)         begin n_fail++; $display("FAIL reset_row: got %0d, required 0", row); end
        if (column !== '0)      begin n_fail++; $display("FAIL reset_column: got %0d, required 0", column); end
        if (bitplane !== '0)    begin n_fail++; $display("FAIL reset_plane: got %0d, required 0", bitplane); end
        inv_on = 1'b1;
        push_idle(4);
        drain();
    endtask

    task automatic test_frame();
        clear_counters();
        brightness = 8'd255;
        build_frame(255, 255);
        push_idle(1); push_frame(FRAME); push_idle(2);
        enable = 1'b1;
        step(1);
        enable = 1'b0;
        drain();
        n_checks += 4;
        if (n_flip != 1) begin n_fail++; $display("FAIL frame_flips: got %0d, required 1", n_flip); end
        if (n_oclk_rise != ROWS * BD * COLS) begin
            n_fail++; $display("FAIL frame_oclk_edges: got %0d, required %0d", n_oclk_rise, ROWS * BD * COLS);
        end
        if (n_lat != ROWS * BD) begin n_fail++; $display("FAIL frame_lat_cycles: got %0d, required %0d", n_lat, ROWS * BD); end
        if (n_oe != ROWS * UNIT * ((1 << BD) - 1)) begin
            n_fail++; $display("FAIL frame_oe_cycles: got %0d, required %0d", n_oe, ROWS * UNIT * ((1 << BD) - 1));
        end
    endtask

    task automatic test_brightness();
        clear_counters();
        brightness = 8'd127;
        build_frame(127, 127);
        push_idle(1); push_frame(FRAME); push_idle(2);
        enable = 1'b1;
        step(1);
        enable = 1'b0;
        drain();
        n_checks++;
        // plane 0: 4 cycles -> 2 on; plane 1: 8 cycles -> 4 on; two rows
        if (n_oe != 12) begin n_fail++; $display("FAIL half_duty_oe: got %0d, required 12", n_oe); end
        brightness = 8'd255;
    endtask

    task automatic test_brightness_sample();
        clear_counters();
        brightness = 8'd255;
        build_frame(255, 0);
        push_idle(1); push_frame(FRAME); push_idle(2);
        enable = 1'b1;
        step(1);
        enable = 1'b0;
        step(11);
        brightness = 8'd0;
        drain();
        n_checks++;
        if (n_oe != UNIT) begin n_fail++; $display("FAIL brightness_latched: got %0d, required %0d", n_oe, UNIT); end
        brightness = 8'd255;
    endtask

    task automatic test_enable_drop();
        clear_counters();
        build_frame(255, 255);
        push_idle(1); push_frame(FRAME); push_idle(3); push_frame(FRAME); push_idle(2);
        enable = 1'b1;
        step(5);
        enable = 1'b0;
        step(FRAME - 2);
        enable = 1'b1;
        step(1);
        enable = 1'b0;
        n_checks++;
        if (row !== '0 || bitplane !== '0 || column !== '0 || oclk !== 1'b0) begin
            n_fail++;
            $display("FAIL restart: got row=%0d plane=%0d col=%0d oclk=%b, required all 0", row, bitplane, column, oclk);
        end
        drain();
        n_checks++;
        if (n_flip != 2) begin n_fail++; $display("FAIL drop_flips: got %0d, required 2", n_flip); end
    endtask

    task automatic test_reset_mid_show();
        clear_counters();
        build_frame(255, 255);
        push_idle(1); push_frame(13); push_idle(1); push_frame(FRAME); push_idle(2);
        enable = 1'b1;
        step(13);
        n_checks++;
        if (oe !== 1'b1) begin n_fail++; $display("FAIL pre_reset_oe: got %b, required 1", oe); end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        n_checks++;
        if (oe !== 1'b0 || lat !== 1'b0 || oclk !== 1'b0) begin
            n_fail++; $display("FAIL reset_edge: got oe=%b lat=%b oclk=%b, required 0 0 0", oe, lat, oclk);
        end
        step(1);
        enable = 1'b0;
        n_checks++;
        if (row !== '0 || bitplane !== '0 || column !== '0) begin
            n_fail++; $display("FAIL post_reset_start: got row=%0d plane=%0d col=%0d, required 0 0 0", row, bitplane, column);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        clear_counters();
        build_frame(255, 255);
        push_idle(1); push_frame(FRAME); push_frame(FRAME); push_idle(2);
        enable = 1'b1;
        step(FRAME + 1);
        enable = 1'b0;
        drain();
        n_checks += 2;
        if (n_flip != 2) begin n_fail++; $display("FAIL b2b_flips: got %0d, required 2", n_flip); end
        if (flip_gap != FRAME) begin n_fail++; $display("FAIL frame_length: got %0d, required %0d", flip_gap, FRAME); end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_frame();
        test_brightness();
        test_brightness_sample();
        test_enable_drop();
        test_reset_mid_show();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
